// File: rtl/fetch_unit_hs_pkg.sv
// Shared types and constants for the fetch unit: state encoding, instruction
// width, branch offset widths and the default NOP word.
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int COND_OFF_W   = 19;
    localparam int UNCOND_OFF_W = 26;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'hD503_201F;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_hs_if.sv
// Instruction-memory request/response bundle. The fetch unit is the master;
// the memory always accepts a request and answers at least one cycle later.
interface fetch_unit_hs_if import fetch_pkg::*; #(
    parameter int ADDR_W = 64
);

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );

endinterface

// File: rtl/fetch_unit_hs_branch_target_gen.sv
// Branch target adder: picks the conditional or unconditional word offset,
// sign-extends it, scales it to bytes and adds it to the branching PC.
module branch_target_gen import fetch_pkg::*; #(
    parameter int ADDR_W = 64
) (
    input  logic                    uncond,
    input  logic [COND_OFF_W-1:0]   cond_off19,
    input  logic [UNCOND_OFF_W-1:0] uncond_off26,
    input  logic [ADDR_W-1:0]       base_pc,
    output logic [ADDR_W-1:0]       target
);

    logic [ADDR_W-1:0] off_s;

    // select the active offset and sign-extend it to the address width
    always_comb begin
        off_s = {ADDR_W{1'b0}};
        if (uncond) begin
            off_s = {{(ADDR_W-UNCOND_OFF_W){uncond_off26[UNCOND_OFF_W-1]}}, uncond_off26};
        end else begin
            off_s = {{(ADDR_W-COND_OFF_W){cond_off19[COND_OFF_W-1]}}, cond_off19};
        end
    end

    // the sum silently wraps modulo 2^ADDR_W
    assign target = base_pc + {off_s[ADDR_W-3:0], 2'b00};

endmodule

// File: rtl/fetch_unit_hs.sv
// Fetch stage: PC register, single-outstanding imem handshake, one-entry skid
// and IF/ID register. Define FETCH_PERF_CNT_EN to add instruction/redirect counters.
module fetch_unit_hs import fetch_pkg::*; #(
    parameter int                 ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC  = {ADDR_W{1'b0}},
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic                    redirect_uncond,
    input  logic [COND_OFF_W-1:0]   cond_off19,
    input  logic [UNCOND_OFF_W-1:0] uncond_off26,
    input  logic [ADDR_W-1:0]       br_pc,
    fetch_unit_hs_if.master         imem,
    output logic [INSTR_W-1:0]      if_id_instr,
    output logic [ADDR_W-1:0]       if_id_pc,
    output logic                    if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_instr_cnt,
    output logic [31:0]             perf_redirect_cnt
`endif
);

    fetch_state_e       state_r, state_s;
    logic [ADDR_W-1:0]  pc_r, pc_s, pc_inc_s, target_s;
    logic [INSTR_W-1:0] skid_instr_r, skid_instr_s;
    logic [ADDR_W-1:0]  skid_pc_r, skid_pc_s;
    logic               load_s;
    logic [INSTR_W-1:0] load_instr_s, if_id_instr_s;
    logic [ADDR_W-1:0]  load_pc_s, if_id_pc_s;
    logic               if_id_valid_s;

    branch_target_gen #(.ADDR_W(ADDR_W)) u_target (
        .uncond       (redirect_uncond),
        .cond_off19   (cond_off19),
        .uncond_off26 (uncond_off26),
        .base_pc      (br_pc),
        .target       (target_s)
    );

    assign pc_inc_s       = pc_r + ADDR_W'(4);
    assign imem.imem_req  = (state_r == FETCH) && !redirect_valid && !reset;
    assign imem.imem_addr = pc_r;

    // next state, PC and skid; a redirect overrides stall and any response
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        skid_instr_s = skid_instr_r;
        skid_pc_s    = skid_pc_r;
        load_s       = 1'b0;
        load_instr_s = imem.imem_rdata;
        load_pc_s    = pc_r;
        if (redirect_valid) begin
            pc_s = target_s;
            // an outstanding response must still be swallowed before refetching
            case (state_r)
                WAIT, DRAIN: state_s = imem.imem_rvalid ? FETCH : DRAIN;
                default:     state_s = FETCH;
            endcase
        end else begin
            case (state_r)
                FETCH: state_s = WAIT;
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        pc_s = pc_inc_s;
                        if (stall) begin
                            skid_instr_s = imem.imem_rdata;
                            skid_pc_s    = pc_r;
                            state_s      = HOLD;
                        end else begin
                            load_s  = 1'b1;
                            state_s = FETCH;
                        end
                    end else begin
                        state_s = WAIT;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        load_s       = 1'b1;
                        load_instr_s = skid_instr_r;
                        load_pc_s    = skid_pc_r;
                        state_s      = FETCH;
                    end else begin
                        state_s = HOLD;
                    end
                end
                DRAIN: state_s = imem.imem_rvalid ? FETCH : DRAIN;
                default: state_s = FETCH;
            endcase
        end
    end

    // IF/ID next value: flush beats load, load beats hold
    always_comb begin
        if (redirect_valid) begin
            if_id_instr_s = NOP_INSTR;
            if_id_pc_s    = if_id_pc;
            if_id_valid_s = 1'b0;
        end else if (load_s) begin
            if_id_instr_s = load_instr_s;
            if_id_pc_s    = load_pc_s;
            if_id_valid_s = 1'b1;
        end else begin
            if_id_instr_s = if_id_instr;
            if_id_pc_s    = if_id_pc;
            if_id_valid_s = if_id_valid;
        end
    end

    // state, PC, skid and IF/ID registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            skid_instr_r <= NOP_INSTR;
            skid_pc_r    <= {ADDR_W{1'b0}};
            if_id_instr  <= NOP_INSTR;
            if_id_pc     <= {ADDR_W{1'b0}};
            if_id_valid  <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            skid_instr_r <= skid_instr_s;
            skid_pc_r    <= skid_pc_s;
            if_id_instr  <= if_id_instr_s;
            if_id_pc     <= if_id_pc_s;
            if_id_valid  <= if_id_valid_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_cnt    <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            if (load_s && !redirect_valid) begin
                perf_instr_cnt <= perf_instr_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_hs.sv
// Bench for fetch_unit_hs: a latency-configurable memory model plus an
// instruction-stream scoreboard (expected next PC, flush and stall rules).
module tb_fetch_unit_hs;
    import fetch_pkg::*;

    localparam int          AW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'hD503_201F;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, redirect_uncond;
    logic [18:0] cond_off19;
    logic [25:0] uncond_off26;
    logic [31:0] br_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_instr_cnt, perf_redirect_cnt;
`endif

    fetch_unit_hs_if #(.ADDR_W(AW)) imem ();

    fetch_unit_hs #(.ADDR_W(AW), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_uncond (redirect_uncond),
        .cond_off19      (cond_off19),
        .uncond_off26    (uncond_off26),
        .br_pc           (br_pc),
        .imem            (imem),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_instr_cnt    (perf_instr_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp, n_fail;
    bit          pend;
    int          pend_cnt, mem_lat;
    logic [31:0] pend_addr, exp_pc;
    bit          obs_req, req_conflict, e_reset, e_stall, e_redir, ld;
    logic [31:0] obs_addr, req_exp, ld_exp, prev_instr, prev_pc;
    logic        prev_valid;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A3C_0F00;
    endfunction

    function automatic logic [31:0] target_of(input logic unc, input logic [18:0] c,
                                              input logic [25:0] u, input logic [31:0] b);
        longint off, sum;
        if (unc) off = longint'($signed(u));
        else     off = longint'($signed(c));
        sum = longint'(b) + off * 4;
        return sum[31:0];
    endfunction

    // one clock: memory answers, request sampled, scoreboard advanced
    task automatic tick();
        @(negedge clk);
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0000_0000;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = word_of(pend_addr);
            end
        end
        #1;
        obs_req = imem.imem_req;  obs_addr = imem.imem_addr;
        req_conflict = obs_req && pend;  req_exp = exp_pc;
        prev_instr = if_id_instr;  prev_pc = if_id_pc;  prev_valid = if_id_valid;
        e_reset = reset;  e_stall = stall;  e_redir = redirect_valid;
        @(posedge clk);
        if (e_reset) begin
            exp_pc = RST_PC;  pend = 1'b0;
        end else begin
            if (imem.imem_rvalid) pend = 1'b0;
            if (obs_req) begin
                pend = 1'b1;  pend_addr = obs_addr;
                pend_cnt = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
            end
            if (e_redir) exp_pc = target_of(redirect_uncond, cond_off19, uncond_off26, br_pc);
        end
        #1;
        ld = !e_reset && if_id_valid && (!prev_valid || if_id_pc != prev_pc);
        ld_exp = exp_pc;
        if (ld) exp_pc = exp_pc + 32'd4;
    endtask

    task automatic do_reset();
        reset = 1'b1;  stall = 1'b0;  redirect_valid = 1'b0;  redirect_uncond = 1'b0;
        cond_off19 = 19'd0;  uncond_off26 = 26'd0;  br_pc = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: req=%b required 0", obs_req); end
        end
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ifid: v=%b instr=%h pc=%h required 0/%h/0", if_id_valid, if_id_instr, if_id_pc, NOP);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        int nld = 0, last = -1;
        logic [31:0] e;
        mem_lat = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ld) begin
                e = 32'(nld * 4);
                n_cmp++;
                if (if_id_pc !== e || if_id_instr !== word_of(e)) begin
                    n_fail++; $display("FAIL seq_load: pc=%h instr=%h required %h/%h", if_id_pc, if_id_instr, e, word_of(e));
                end
                if (nld > 0) begin
                    n_cmp++;
                    if (i - last != 2) begin n_fail++; $display("FAIL seq_gap: gap=%0d required 2", i - last); end
                end
                last = i;  nld++;
            end
        end
        n_cmp++;
        if (nld != 6) begin n_fail++; $display("FAIL seq_count: loads=%0d required 6", nld); end
    endtask

    task automatic test_stall();
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (!obs_req || obs_addr !== 32'h8) begin n_fail++; $display("FAIL stall_req8: req=%b addr=%h required 1/8", obs_req, obs_addr); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_id_pc !== 32'h4 || if_id_valid !== 1'b1 || obs_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold: pc=%h v=%b req=%b required 4/1/0", if_id_pc, if_id_valid, obs_req);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (if_id_pc !== 32'h8 || if_id_instr !== word_of(32'h8) || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: pc=%h instr=%h required 8/%h", if_id_pc, if_id_instr, word_of(32'h8));
        end
        tick();
        n_cmp++;
        if (!obs_req || obs_addr !== 32'hC) begin n_fail++; $display("FAIL stall_next_req: req=%b addr=%h required 1/c", obs_req, obs_addr); end
        tick();
        n_cmp++;
        if (!ld || if_id_pc !== 32'hC) begin n_fail++; $display("FAIL stall_next_load: ld=%b pc=%h required 1/c", ld, if_id_pc); end
    endtask

    task automatic test_redirect_cond();
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 3; i++) tick();
        redirect_valid = 1'b1;  redirect_uncond = 1'b0;  cond_off19 = 19'h7FFFF;  br_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            n_fail++; $display("FAIL redir_flush: v=%b instr=%h required 0/%h", if_id_valid, if_id_instr, NOP);
        end
        tick();
        n_cmp++;
        if (!obs_req || obs_addr !== 32'hFC) begin n_fail++; $display("FAIL redir_addr: req=%b addr=%h required 1/fc", obs_req, obs_addr); end
        tick();
        n_cmp++;
        if (!ld || if_id_pc !== 32'hFC || if_id_instr !== word_of(32'hFC)) begin
            n_fail++; $display("FAIL redir_load: ld=%b pc=%h instr=%h required 1/fc/%h", ld, if_id_pc, if_id_instr, word_of(32'hFC));
        end
    endtask

    task automatic test_redirect_wait();
        bit got = 1'b0;
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 5; i++) tick();
        redirect_valid = 1'b1;  redirect_uncond = 1'b1;  uncond_off26 = 26'h10;  br_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_flush: v=%b required 0", if_id_valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs_req !== 1'b0 || if_id_valid !== 1'b0) begin
                n_fail++; $display("FAIL drain_quiet: req=%b v=%b required 0/0", obs_req, if_id_valid);
            end
        end
        tick();
        n_cmp++;
        if (!obs_req || obs_addr !== 32'h80) begin n_fail++; $display("FAIL drain_refetch: req=%b addr=%h required 1/80", obs_req, obs_addr); end
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (ld) got = 1'b1;
        end
        n_cmp++;
        if (!got || if_id_pc !== 32'h80 || if_id_instr !== word_of(32'h80)) begin
            n_fail++; $display("FAIL drain_load: got=%b pc=%h instr=%h required 1/80/%h", got, if_id_pc, if_id_instr, word_of(32'h80));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_lat = 1;
        tick();  tick();
        redirect_valid = 1'b1;  redirect_uncond = 1'b0;  cond_off19 = 19'd3;  br_pc = 32'hFFFF_FFF0;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++;
        if (!obs_req || obs_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: req=%b addr=%h required 1/fffffffc", obs_req, obs_addr); end
        tick();
        n_cmp++;
        if (!ld || if_id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_load: pc=%h required fffffffc", if_id_pc); end
        tick();
        n_cmp++;
        if (!obs_req || obs_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero: req=%b addr=%h required 1/0", obs_req, obs_addr); end
        tick();
        n_cmp++;
        if (!ld || if_id_pc !== 32'h0 || if_id_instr !== word_of(32'h0)) begin n_fail++; $display("FAIL wrap_zero_load: pc=%h required 0", if_id_pc); end
        redirect_valid = 1'b1;  cond_off19 = 19'h7FFFE;  br_pc = 32'h4;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++;
        if (!obs_req || obs_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_neg: req=%b addr=%h required 1/fffffffc", obs_req, obs_addr); end
        reset = 1'b1;  redirect_valid = 1'b1;  cond_off19 = 19'h10;  br_pc = 32'h500;
        tick();
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0 || obs_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_vs_redir: v=%b instr=%h pc=%h req=%b", if_id_valid, if_id_instr, if_id_pc, obs_req);
        end
        reset = 1'b0;  redirect_valid = 1'b0;
        tick();
        n_cmp++;
        if (!obs_req || obs_addr !== RST_PC) begin n_fail++; $display("FAIL reset_vs_redir_pc: addr=%h required %h", obs_addr, RST_PC); end
    endtask

    task automatic test_random();
        int got = 0;
        do_reset();
        mem_lat = 0;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(99, 0) < 25);
            redirect_valid = ($urandom_range(99, 0) < 8);
            redirect_uncond = 1'($urandom_range(1, 0));
            cond_off19 = 19'($urandom);  uncond_off26 = 26'($urandom);  br_pc = $urandom;
            tick();
            if (obs_req) begin
                n_cmp++;
                if (req_conflict || obs_addr !== req_exp) begin
                    n_fail++; $display("FAIL rnd_req: addr=%h busy=%b required %h/0", obs_addr, req_conflict, req_exp);
                end
            end
            if (e_redir) begin
                n_cmp++;
                if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin n_fail++; $display("FAIL rnd_flush: v=%b instr=%h", if_id_valid, if_id_instr); end
            end else if (e_stall) begin
                n_cmp++;
                if (if_id_valid !== prev_valid || if_id_pc !== prev_pc || if_id_instr !== prev_instr) begin
                    n_fail++; $display("FAIL rnd_stall: pc=%h v=%b required %h/%b", if_id_pc, if_id_valid, prev_pc, prev_valid);
                end
            end
            if (ld) begin
                n_cmp++;
                if (if_id_pc !== ld_exp || if_id_instr !== word_of(ld_exp)) begin
                    n_fail++; $display("FAIL rnd_load: pc=%h instr=%h required %h/%h", if_id_pc, if_id_instr, ld_exp, word_of(ld_exp));
                end
            end
        end
        stall = 1'b0;  redirect_valid = 1'b0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            tick();
            if (ld) got++;
        end
        n_cmp++;
        if (got == 0) begin n_fail++; $display("FAIL rnd_live: no instruction within 30 cycles"); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        int nld = 0;
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 80 && nld < 10; i++) begin
            redirect_valid = (i == 4 || i == 9);
            redirect_uncond = 1'b0;  cond_off19 = 19'd8;  br_pc = 32'h200;
            tick();
            if (ld) nld++;
        end
        redirect_valid = 1'b0;
        n_cmp++;
        if (nld != 10 || perf_instr_cnt !== 32'd10 || perf_redirect_cnt !== 32'd2) begin
            n_fail++; $display("FAIL perf_cnt: loads=%0d instr=%0d redir=%0d required 10/10/2", nld, perf_instr_cnt, perf_redirect_cnt);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;  n_fail = 0;  pend = 1'b0;  pend_cnt = 0;  mem_lat = 1;
        pend_addr = 32'h0;  exp_pc = RST_PC;
        reset = 1'b1;  stall = 1'b0;  redirect_valid = 1'b0;  redirect_uncond = 1'b0;
        cond_off19 = 19'd0;  uncond_off26 = 26'd0;  br_pc = 32'h0;
        imem.imem_rvalid = 1'b0;  imem.imem_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_cond();
        test_redirect_wait();
        test_wrap();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
